matrix_addsub_seq: RTL and testbench
====================================

MATRIX_ADDSUB_SEQ -- requirements
Module: matrix_addsub_seq

Interface
REQ-001 The block SHALL use synchronous, active-high reset: one clock `clk`, with all state sampled on its rising edge and reset by `reset`.
REQ-002 The block SHALL have these parameters:
- ELEM_W, default 8: signed two's-complement element width.
- MAX_DIM, default 5: largest square dimension.
- LANES, default 5: elements processed per cycle.
- SZ_W, default 2: matrix_size width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request pulse
- op  in  1  0=A+B, 1=A-B
- matrix_size  in  SZ_W  dimension = value+2
- matrix_A  in  MAX_DIM*MAX_DIM*ELEM_W  operand A, densely packed
- matrix_B  in  MAX_DIM*MAX_DIM*ELEM_W  operand B, densely packed
- result_out  out  MAX_DIM*MAX_DIM*ELEM_W  result
- overflow  out  1  sticky per-operation overflow
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Function
REQ-004 Element k = r*n+c SHALL occupy bits [k*ELEM_W +: ELEM_W], with n = matrix_size+2, and n clamped to MAX_DIM when matrix_size+2 exceeds MAX_DIM.
REQ-005 The FSM SHALL have three states, IDLE, RUN and DONE, and busy SHALL be 1 exactly when the state is not IDLE.
REQ-006 On start=1 in IDLE, the block SHALL do all of the following in the same cycle:
- latch matrix_A, matrix_B, op and n;
- clear result_out and overflow;
- set the index idx=0;
- enter RUN.
REQ-007 start SHALL be ignored in RUN and DONE, and inputs SHALL NOT be re-sampled after the latch cycle.
REQ-008 Each RUN cycle SHALL compute elements idx..idx+LANES-1 that are below n*n, write them into result_out, and then set idx += LANES.
REQ-009 RUN SHALL last C = ceil(n*n/LANES) cycles and then go to DONE; with defaults this gives C=1, 2, 4, 5 for n=2, 3, 4, 5.
REQ-010 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-011 Latency SHALL be fixed: start accepted at cycle T gives done=1 at cycle T+C+1.
REQ-012 result_out elements with index ≥ n*n SHALL read 0.
REQ-013 result_out and overflow SHALL hold their values from DONE until the next accepted start.
REQ-014 Add overflow SHALL be detected when the operands have equal sign bits and the ELEM_W-bit result sign differs from A.
REQ-015 Subtract overflow SHALL be detected when the operand sign bits differ and the result sign differs from A.
REQ-016 overflow SHALL be the OR of per-element overflows over all active elements only.
REQ-017 Partial results in result_out SHALL be visible during RUN, but they are valid only once done=1.

Reset
REQ-018 When reset=1, the block SHALL force state=IDLE, idx=0, result_out=0, overflow=0, busy=0 and done=0 at the next edge.
REQ-019 Reset SHALL take priority over start.
REQ-020 Reset asserted mid-RUN SHALL abort the operation with no done pulse.

Configuration
REQ-021 With MATRIX_SAT_EN defined, an element that overflows SHALL saturate: to 2^(ELEM_W-1)-1 on positive overflow and to -2^(ELEM_W-1) on negative overflow.
REQ-022 Without MATRIX_SAT_EN, results SHALL wrap modulo 2^ELEM_W.
REQ-023 The overflow flag SHALL behave identically with or without MATRIX_SAT_EN.

Structure
REQ-024 Shared package matrix_pkg SHALL hold:
- ELEM_W, MAX_DIM and LANES defaults;
- the OP_ADD and OP_SUB encodings;
- the FSM state encoding;
- the size-to-dimension mapping function.
REQ-025 A combinational sub-module, matrix_elem_alu (one element: add/sub, overflow, optional saturation), SHALL be instantiated LANES times.

Verification
REQ-026 A directed bench SHALL cover the following scenarios:
- Size 00, op=1, A=[10,20,30,40], B=[3,5,7,9]:
  - Required: result=[7,15,23,31], overflow=0, rest zero.
  - Required: done exactly 2 cycles after start.
- Size 11, op=0, A all 0x7F, B all 0x01:
  - Without MATRIX_SAT_EN: all 25 results 0x80.
  - With MATRIX_SAT_EN: all 25 results 0x7F.
  - Both builds: overflow=1, done at T+6.
- Size 01, op=1, A[8]=0x80, B[8]=0x01, all other elements 0:
  - Without MATRIX_SAT_EN: result[8]=0x7F.
  - With MATRIX_SAT_EN: result[8]=0x80.
  - Both builds: overflow=1.
- Size 01, element 9 overflows, but only elements 0-8 are active:
  - Required: overflow=0, result[9]=0.
- start pulsed every cycle during a size-10 operation:
  - Required: exactly one done, and results match the first latched operands.
- reset asserted in the 3rd RUN cycle of a size-11 operation:
  - Required: next cycle busy=0, result_out=0, overflow=0, and no done.
  - Required: a following start runs normally.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix add/subtract engine.
// Holds default sizes, op encodings, FSM states and size decode.
package matrix_pkg;

  localparam int DEF_ELEM_W  = 8;
  localparam int DEF_MAX_DIM = 5;
  localparam int DEF_LANES   = 5;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // matrix_size encodes dimension-2, clamped to the largest supported.
  function automatic int dim_of(input int sz, input int max_dim);
    int n;
    n = sz + 2;
    if (n > max_dim) n = max_dim;
    return n;
  endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Single-element signed add/sub with overflow detect.
// Saturates overflowing results when MATRIX_SAT_EN is defined.
module matrix_elem_alu
  import matrix_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic              op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y,
  output logic              ovf
);

  logic [ELEM_W-1:0] raw;
  logic sa, sb, sr;

  // Wrapped result, sign-rule overflow, optional clamp.
  always_comb begin
    raw = (op == OP_SUB) ? a - b : a + b;
    sa  = a[ELEM_W-1];
    sb  = b[ELEM_W-1];
    sr  = raw[ELEM_W-1];
    if (op == OP_SUB) ovf = (sa != sb) && (sr != sa);
    else              ovf = (sa == sb) && (sr != sa);
`ifdef MATRIX_SAT_EN
    if (ovf) y = sa ? {1'b1, {(ELEM_W-1){1'b0}}}
                    : {1'b0, {(ELEM_W-1){1'b1}}};
    else     y = raw;
`else
    y = raw;
`endif
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential matrix A+B / A-B, LANES elements per cycle.
// Optional saturation via MATRIX_SAT_EN (see matrix_elem_alu).
module matrix_addsub_seq
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int LANES   = DEF_LANES,
  parameter int SZ_W    = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              op,
  input  logic [SZ_W-1:0]                   matrix_size,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_A,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_B,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] result_out,
  output logic                              overflow,
  output logic                              busy,
  output logic                              done
);

  localparam int NE = MAX_DIM * MAX_DIM;
  localparam int VW = NE * ELEM_W;
  localparam int IW = $clog2(NE + LANES + 1);

  state_t state, state_d;

  logic [IW-1:0] idx, nn_q;
  logic          op_q;
  logic [VW-1:0] a_q, b_q, res_q;
  logic          ovf_q;
  logic          accept, last;
  int            dim_n;

  logic [ELEM_W-1:0] la [LANES];
  logic [ELEM_W-1:0] lb [LANES];
  logic [ELEM_W-1:0] ly [LANES];
  logic [LANES-1:0]  lact, lovf;

  assign dim_n  = dim_of(int'(matrix_size), MAX_DIM);
  assign accept = (state == S_IDLE) && start;
  assign last   = (int'(idx) + LANES) >= int'(nn_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d = state;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    unique case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch the operands for this cycle's lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      int e;
      e       = int'(idx) + l;
      lact[l] = e < int'(nn_q);
      la[l]   = '0;
      lb[l]   = '0;
      if (e < NE) begin
        la[l] = a_q[e*ELEM_W +: ELEM_W];
        lb[l] = b_q[e*ELEM_W +: ELEM_W];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    matrix_elem_alu #(.ELEM_W(ELEM_W)) u_alu (
      .op  (op_q),
      .a   (la[g]),
      .b   (lb[g]),
      .y   (ly[g]),
      .ovf (lovf[g])
    );
  end

  // Latch on accept, then write active lanes each RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      nn_q  <= '0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      nn_q  <= IW'(dim_n * dim_n);
      op_q  <= op;
      a_q   <= matrix_A;
      b_q   <= matrix_B;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == S_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        if (lact[l])
          res_q[(int'(idx)+l)*ELEM_W +: ELEM_W] <= ly[l];
      end
      ovf_q <= ovf_q | (|(lovf & lact));
      idx   <= idx + IW'(LANES);
    end
  end

  assign result_out = res_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Self-checking bench for matrix_addsub_seq.
// Directed scenarios plus randomized ops against an integer model.
module tb_matrix_addsub_seq;

  localparam int EW = 8;
  localparam int MD = 5;
  localparam int LN = 5;
  localparam int VW = MD*MD*EW;

  logic          clk = 1'b0;
  logic          reset, start, op;
  logic [1:0]    matrix_size;
  logic [VW-1:0] matrix_A, matrix_B, result_out;
  logic          overflow, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_addsub_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .matrix_size (matrix_size),
    .matrix_A    (matrix_A),
    .matrix_B    (matrix_B),
    .result_out  (result_out),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag,
                     input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dimf(input logic [1:0] sz);
    int n;
    n = int'(sz) + 2;
    return (n > MD) ? MD : n;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < MD*MD; i++)
      v[i*EW +: EW] = 8'($urandom);
    return v;
  endfunction

  // Reference: true integer sum/difference, range-checked.
  task automatic model(input logic [1:0] sz, input logic o,
                       input logic [VW-1:0] a, b,
                       output logic [VW-1:0] r,
                       output logic ov);
    int n, x, y, s;
    logic [31:0] t;
    n  = dimf(sz);
    r  = '0;
    ov = 1'b0;
    for (int k = 0; k < n*n; k++) begin
      x = $signed(a[k*EW +: EW]);
      y = $signed(b[k*EW +: EW]);
      s = o ? x - y : x + y;
      if (s > 127 || s < -128) begin
        ov = 1'b1;
`ifdef MATRIX_SAT_EN
        s = (s > 127) ? 127 : -128;
`endif
      end
      t = s;
      r[k*EW +: EW] = t[7:0];
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] sz,
                        input logic o,
                        input logic [VW-1:0] a, b,
                        input bit spam,
                        output logic [VW-1:0] r_obs,
                        output logic ov_obs);
    int n, cexp, lat;
    logic [VW-1:0] r_exp;
    logic ov_exp;
    n    = dimf(sz);
    cexp = (n*n + LN - 1) / LN;
    model(sz, o, a, b, r_exp, ov_exp);
    matrix_size = sz;
    op          = o;
    matrix_A    = a;
    matrix_B    = b;
    start       = 1'b1;
    step();
    if (!spam) start = 1'b0;
    chk({tag, "_busy"}, VW'(busy), VW'(1));
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (spam) begin
        matrix_A    = rnd_vec();
        matrix_B    = rnd_vec();
        op          = ~op;
        matrix_size = 2'($urandom);
      end
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, VW'(lat), VW'(cexp));
    chk({tag, "_res"}, result_out, r_exp);
    chk({tag, "_ovf"}, VW'(overflow), VW'(ov_exp));
    r_obs  = result_out;
    ov_obs = overflow;
    step();
    chk({tag, "_done1"}, VW'(done), VW'(0));
    chk({tag, "_idle"}, VW'(busy), VW'(0));
    chk({tag, "_hold"}, result_out, r_exp);
    chk({tag, "_hovf"}, VW'(overflow), VW'(ov_exp));
  endtask

  initial begin
    logic [VW-1:0] a, b, r, exp_v;
    logic ov;
    bit saw_done;

    reset       = 1'b1;
    start       = 1'b0;
    op          = 1'b0;
    matrix_size = '0;
    matrix_A    = '0;
    matrix_B    = '0;
    step();
    step();
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_res", result_out, '0);
    chk("rst_ovf", VW'(overflow), VW'(0));
    reset = 1'b0;
    step();

    a = '0;
    b = '0;
    a[31:0] = 32'h281e140a;
    b[31:0] = 32'h09070503;
    run_op("sub2", 2'b00, 1'b1, a, b, 1'b0, r, ov);
    exp_v = '0;
    exp_v[31:0] = 32'h1f170f07;
    chk("sub2_const", r, exp_v);
    chk("sub2_cov", VW'(ov), VW'(0));

    for (int i = 0; i < MD*MD; i++) begin
      a[i*EW +: EW] = 8'h7f;
      b[i*EW +: EW] = 8'h01;
    end
    run_op("add5", 2'b11, 1'b0, a, b, 1'b0, r, ov);
    for (int i = 0; i < MD*MD; i++)
`ifdef MATRIX_SAT_EN
      exp_v[i*EW +: EW] = 8'h7f;
`else
      exp_v[i*EW +: EW] = 8'h80;
`endif
    chk("add5_const", r, exp_v);
    chk("add5_cov", VW'(ov), VW'(1));

    a = '0;
    b = '0;
    a[8*EW +: EW] = 8'h80;
    b[8*EW +: EW] = 8'h01;
    run_op("neg3", 2'b01, 1'b1, a, b, 1'b0, r, ov);
`ifdef MATRIX_SAT_EN
    chk("neg3_e8", VW'(r[8*EW +: EW]), VW'(8'h80));
`else
    chk("neg3_e8", VW'(r[8*EW +: EW]), VW'(8'h7f));
`endif
    r[8*EW +: EW] = '0;
    chk("neg3_rest", r, '0);
    chk("neg3_cov", VW'(ov), VW'(1));

    a = '0;
    b = '0;
    a[9*EW +: EW] = 8'h7f;
    b[9*EW +: EW] = 8'h01;
    run_op("inact", 2'b01, 1'b0, a, b, 1'b0, r, ov);
    chk("inact_res", r, '0);
    chk("inact_cov", VW'(ov), VW'(0));

    run_op("spam", 2'b10, 1'b0, rnd_vec(), rnd_vec(),
           1'b1, r, ov);
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    chk("spam_one", VW'(saw_done), VW'(0));

    matrix_size = 2'b11;
    op          = 1'b0;
    matrix_A    = rnd_vec();
    matrix_B    = rnd_vec();
    start       = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_res", result_out, '0);
    chk("abort_ovf", VW'(overflow), VW'(0));
    chk("abort_done", VW'(done), VW'(0));
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    chk("abort_nodone", VW'(saw_done), VW'(0));
    run_op("after", 2'b11, 1'b1, rnd_vec(), rnd_vec(),
           1'b0, r, ov);

    for (int t = 0; t < 12; t++) begin
      a = rnd_vec();
      b = rnd_vec();
      run_op($sformatf("rnd%0d", t), 2'($urandom),
             1'($urandom), a, b, 1'b0, r, ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
